forwarding_hazard_unit: RTL
===========================

// Module: forwarding_hazard_unit
// PURPOSE
//   Producer side of the Execute-stage forwarding interface: generates FU_Src_Sel/FU_Dst_Sel and the load-use stall.
//   Keeps a shadow pipeline of destination-register records (EX and MEM slots) that advances with the main pipeline.
//   Registers both selects on the same clk edge on which the decoded instruction enters EX.
//   Sits between Decode and Execute; its stall output freezes PC and IF/ID.
// PARAMETERS
//   REG_AW  3   register-index width (R0..R7, no hard-wired zero register)
//   SEL_W   2   forwarding-select width
//   CNT_W   16  stall-counter width (used only with FHU_STALL_CNT_EN)
// PORTS
//   clk          in   1       pipeline clock, rising edge
//   rst          in   1       synchronous, active-high reset
//   id_valid     in   1       Decode holds a real instruction
//   id_src_reg   in   REG_AW  Rsrc index of the decoded instruction
//   id_src_rd    in   1       decoded instruction reads Rsrc as an operand
//   id_dst_reg   in   REG_AW  Rdst index (operand and/or destination)
//   id_dst_rd    in   1       decoded instruction reads Rdst as an operand
//   id_wb_en     in   1       decoded instruction writes Rdst
//   id_mem_read  in   1       decoded instruction is a load (result ready after MEM)
//   flush        in   1       taken branch/jump: kill the instruction entering EX
//   FU_Src_Sel   out  SEL_W   EX Rsrc operand source (registered)
//   FU_Dst_Sel   out  SEL_W   EX Rdst operand source (registered)
//   stall        out  1       combinational: hold PC and IF/ID, insert bubble into EX
//   stall_cnt    out  CNT_W   saturating stall-cycle count (FHU_STALL_CNT_EN only)
// BEHAVIOUR
//   - Select encoding: 00 = register file, 01 = ALU_After_E_M, 10 = WB value; 11 is never driven.
//   - Record = {valid, dst, wb_en, mem_read}. Slots: ex_q (instruction now in EX), mem_q (instruction now in MEM).
//   - stall = id_valid & ex_q.valid & ex_q.mem_read & ex_q.wb_en & ~flush
//             & ((id_src_rd & id_src_reg==ex_q.dst) | (id_dst_rd & id_dst_reg==ex_q.dst)).
//   - Each clk edge: mem_q <= ex_q; ex_q <= (flush|stall|~id_valid) ? bubble (valid=0) : ID fields.
//   - Per operand, when ID is loaded into EX:
//       * sel <= 01 if op_rd & ex_q.valid & ex_q.wb_en & ~ex_q.mem_read & dst==op.
//       * Otherwise sel <= 10 if op_rd & mem_q.valid & mem_q.wb_en & dst==op.
//       * Otherwise sel <= 00.
//     The younger producer (E/M) has priority over WB.
//   - On a bubble, both selects <= 00.
//   - A load in ex_q is never forwarded from E/M. The stall bubble moves it to mem_q, so the consumer receives 10.
//   - The register file is write-through in WB, so a producer older than mem_q needs no forwarding.
//   - Src and Dst are evaluated independently: both may select the same producer.
//   - Latency: selects are valid in the cycle the instruction sits in EX (one edge after it was in ID).
//   - Simultaneous flush and stall: flush wins, so stall=0 and a bubble is inserted.
//   - Reset: ex_q and mem_q invalid, FU_Src_Sel=FU_Dst_Sel=00, stall=0, stall_cnt=0.
//     A reset mid-operation discards all in-flight records.
// CONFIGURATION
//   FHU_STALL_CNT_EN defined:
//     - stall_cnt increments on every clk with stall=1 and rst=0.
//     - It saturates at all-ones and clears only on rst.
//   FHU_STALL_CNT_EN undefined:
//     - stall_cnt port and counter are absent.
//     - All other behaviour is identical.
// STRUCTURE
//   - pipeline_pkg: FWD_REGFILE/FWD_EM/FWD_MWB select constants, REG_AW, stage-record typedef.
//     Shared with ExecuteStage.
//   - Sub-module fwd_sel_compare, instantiated twice (Src, Dst):
//     op index + op_rd + ex_q + mem_q -> next select.
// TESTING
//   1 Reset held 2 cycles with id_valid=1 -> selects 00, stall 0, stall_cnt 0.
//   2 Back-to-back ADD: ADD R1,R2 (wb R1) then ADD R3,R1 (src R1) -> second instruction in EX has FU_Src_Sel=01.
//   3 Producer-gap-consumer: ADD R4; NOP; SUB R4,R5 reading R4 -> FU_Dst_Sel=10, FU_Src_Sel=00.
//   4 Load-use: LDD R2 then ADD R3,R2.
//     -> stall=1 for exactly 1 cycle, bubble with selects 00, then consumer in EX with FU_Src_Sel=10.
//   5 Double producer: ADD R1; ADD R1; ADD R1,R1 (both operands R1) -> both selects 01 (younger wins).
//   6 Load-use plus flush in the same cycle -> stall=0, bubble inserted.
//     Same scenario with FHU_STALL_CNT_EN defined -> stall_cnt does not increment; it increments by 1 in test 4.

Source files
------------

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, widths and the shadow stage record.
// Also used by ExecuteStage, so the select constants must stay in step with its operand muxes.
package pipeline_pkg;

  localparam int REG_AW = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  localparam logic [SEL_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [SEL_W-1:0] FWD_EM      = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MWB     = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wb_en;
    logic              mem_read;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '{valid: 1'b0, dst: '0, wb_en: 1'b0, mem_read: 1'b0};

  // A stage record "produces" an index when it holds a real instruction that writes it.
  function automatic logic rec_hit(input stage_rec_t rec, input logic [REG_AW-1:0] idx);
    return rec.valid & rec.wb_en & (rec.dst == idx);
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Decode-to-hazard-unit bundle: decoded operand info in, forwarding selects and stall out.
// stall_cnt exists only when FHU_STALL_CNT_EN is defined.
interface forwarding_hazard_unit_if;
  import pipeline_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_src_reg;
  logic              id_src_rd;
  logic [REG_AW-1:0] id_dst_reg;
  logic              id_dst_rd;
  logic              id_wb_en;
  logic              id_mem_read;
  logic              flush;
  logic [SEL_W-1:0]  FU_Src_Sel;
  logic [SEL_W-1:0]  FU_Dst_Sel;
  logic              stall;
`ifdef FHU_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  modport master (
`ifdef FHU_STALL_CNT_EN
    input  stall_cnt,
`endif
    output id_valid, id_src_reg, id_src_rd, id_dst_reg, id_dst_rd,
    output id_wb_en, id_mem_read, flush,
    input  FU_Src_Sel, FU_Dst_Sel, stall
  );

  modport slave (
`ifdef FHU_STALL_CNT_EN
    output stall_cnt,
`endif
    input  id_valid, id_src_reg, id_src_rd, id_dst_reg, id_dst_rd,
    input  id_wb_en, id_mem_read, flush,
    output FU_Src_Sel, FU_Dst_Sel, stall
  );

endinterface

// File: rtl/forwarding_hazard_unit_fwd_sel_compare.sv
// Next-cycle forwarding select for one operand, from the EX and MEM shadow records.
// The younger EX producer wins over MEM; a load in EX cannot forward (its data is not ready yet).
module fwd_sel_compare
  import pipeline_pkg::*;
(
  input  logic [REG_AW-1:0] i_op_reg,
  input  logic              i_op_rd,
  input  stage_rec_t        i_ex_q,
  input  stage_rec_t        i_mem_q,
  output logic [SEL_W-1:0]  o_sel
);

  always_comb begin
    o_sel = FWD_REGFILE;
    if (i_op_rd && rec_hit(i_ex_q, i_op_reg) && !i_ex_q.mem_read)
      o_sel = FWD_EM;
    else if (i_op_rd && rec_hit(i_mem_q, i_op_reg))
      o_sel = FWD_MWB;
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Execute-stage forwarding/hazard unit: shadow EX/MEM destination records, registered selects, load-use stall.
// Optional saturating stall counter enabled by defining FHU_STALL_CNT_EN.
module forwarding_hazard_unit
  import pipeline_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  forwarding_hazard_unit_if.slave bus
);

  stage_rec_t       r_ex_q;
  stage_rec_t       r_mem_q;
  logic [SEL_W-1:0] r_src_sel;
  logic [SEL_W-1:0] r_dst_sel;
  logic [SEL_W-1:0] w_src_sel_nxt;
  logic [SEL_W-1:0] w_dst_sel_nxt;
  logic             w_stall;
  logic             w_load_ex;

  // Load in EX feeding an operand of the instruction in ID; a flush kills the consumer instead.
  assign w_stall = bus.id_valid & r_ex_q.valid & r_ex_q.mem_read & r_ex_q.wb_en & ~bus.flush
                 & ((bus.id_src_rd & (bus.id_src_reg == r_ex_q.dst))
                  | (bus.id_dst_rd & (bus.id_dst_reg == r_ex_q.dst)));

  assign w_load_ex = bus.id_valid & ~bus.flush & ~w_stall;

  fwd_sel_compare u_src_cmp (
    .i_op_reg (bus.id_src_reg),
    .i_op_rd  (bus.id_src_rd),
    .i_ex_q   (r_ex_q),
    .i_mem_q  (r_mem_q),
    .o_sel    (w_src_sel_nxt)
  );

  fwd_sel_compare u_dst_cmp (
    .i_op_reg (bus.id_dst_reg),
    .i_op_rd  (bus.id_dst_rd),
    .i_ex_q   (r_ex_q),
    .i_mem_q  (r_mem_q),
    .o_sel    (w_dst_sel_nxt)
  );

  // ID -> EX boundary: records advance and selects register with the instruction entering EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_q    <= BUBBLE;
      r_mem_q   <= BUBBLE;
      r_src_sel <= FWD_REGFILE;
      r_dst_sel <= FWD_REGFILE;
    end else begin
      r_mem_q <= r_ex_q;
      if (w_load_ex) begin
        r_ex_q    <= '{valid: 1'b1, dst: bus.id_dst_reg, wb_en: bus.id_wb_en,
                       mem_read: bus.id_mem_read};
        r_src_sel <= w_src_sel_nxt;
        r_dst_sel <= w_dst_sel_nxt;
      end else begin
        r_ex_q    <= BUBBLE;
        r_src_sel <= FWD_REGFILE;
        r_dst_sel <= FWD_REGFILE;
      end
    end
  end

  assign bus.FU_Src_Sel = r_src_sel;
  assign bus.FU_Dst_Sel = r_dst_sel;
  assign bus.stall      = w_stall;

`ifdef FHU_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
